// File: rtl/serial_channel_scheduler.sv
// Round-robin scheduler time-sharing one serializer between NUM_CH one-deep channel holding registers.
// Latency: a word captured at edge t is granted at edge t+1 when idle; its load strobe is high in the following cycle.
// No backpressure: an un-sent word is overwritten by a newer one and flagged in a sticky per-channel overflow bit.
module serial_channel_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int LENGTH  = 24,
  localparam int CH_BITS = $clog2(NUM_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic [NUM_CH*LENGTH-1:0] iv_din,
  input  logic [NUM_CH-1:0]        iv_din_valid,
  input  logic                     i_ovf_clr,
  output logic [LENGTH-1:0]        ov_ser_din,
  output logic                     o_ser_load,
  output logic [CH_BITS-1:0]       ov_ser_ch,
  output logic                     o_busy,
  output logic [NUM_CH-1:0]        ov_pending,
  output logic [NUM_CH-1:0]        ov_overflow
);

  localparam int CNT_W = $clog2(LENGTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CH_BITS-1:0] ptr_q;
  logic [LENGTH-1:0]  word_q [NUM_CH];
  logic [NUM_CH-1:0]  pend_q, ovf_q, ovf_set;
  logic               load_q, busy_q;
  logic [LENGTH-1:0]  ser_din_q;
  logic [CH_BITS-1:0] ser_ch_q;
  logic               arb, gnt_vld, gnt_fire;
  logic [CH_BITS-1:0] gnt_idx, cand;
  int                 c;

  // Round-robin search: first pending channel after the last grant, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    c       = 0;
    cand    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      c    = (int'(ptr_q) + i) % NUM_CH;
      cand = CH_BITS'(c);
      if (!gnt_vld && pend_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Next-state logic: arbitrate when idle or on the last enabled cycle of a slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arb     = 1'b0;
    if (i_en) begin
      case (state_q)
        IDLE: begin
          arb = 1'b1;
          if (gnt_vld) state_d = LOAD;
        end
        LOAD: begin
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LENGTH - 1)) begin
            arb     = 1'b1;
            state_d = gnt_vld ? LOAD : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign gnt_fire = arb & gnt_vld;

  // Overflow: a new word lands on a still-pending word that is not leaving on this edge.
  always_comb begin
    ovf_set = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ovf_set[k] = iv_din_valid[k] & pend_q[k] & ~(gnt_fire && (gnt_idx == CH_BITS'(k)));
    end
  end

  // FSM state and slot counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant bookkeeping and registered serializer-side outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q     <= CH_BITS'(NUM_CH - 1);
      ser_din_q <= '0;
      ser_ch_q  <= '0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (gnt_fire) begin
        ptr_q     <= gnt_idx;
        ser_din_q <= word_q[gnt_idx];
        ser_ch_q  <= gnt_idx;
      end
      if (i_en) begin
        load_q <= gnt_fire;
        busy_q <= (state_d != IDLE);
      end
    end
  end

  // Holding registers: capture runs every edge regardless of the enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_CH; k++) word_q[k] <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (iv_din_valid[k]) begin
          word_q[k] <= iv_din[k*LENGTH +: LENGTH];
          pend_q[k] <= 1'b1;
        end else if (gnt_fire && (gnt_idx == CH_BITS'(k))) begin
          pend_q[k] <= 1'b0;
        end
      end
      ovf_q <= (ovf_q & ~{NUM_CH{i_ovf_clr}}) | ovf_set;
    end
  end

  // The strobe is qualified by the enable so a stalled LOAD cycle never shows a load.
  assign o_ser_load  = load_q & i_en;
  assign ov_ser_din  = ser_din_q;
  assign ov_ser_ch   = ser_ch_q;
  assign o_busy      = busy_q;
  assign ov_pending  = pend_q;
  assign ov_overflow = ovf_q;

endmodule
